// File: rtl/periph_pkg.sv
// periph_pkg: shared constants for the SPI-mapped peripheral bundle.
//   DW       register / FIFO entry width
//   DEPTH    packet FIFO storage entries
//   PTR_W    FIFO pointer width (pointers wrap modulo DEPTH)
//   CNT_W    width of the FIFO write/read byte counters (saturating)
//   reg_addr_e  register map seen by the regwrap decoder
package periph_pkg;

    localparam int unsigned DW    = 8;
    localparam int unsigned DEPTH = 64;
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = 8;

    typedef enum logic [7:0] {
        REG_GPO       = 8'h02,
        REG_LED       = 8'h03,
        REG_FIFO_LEN  = 8'h04,
        REG_FIFO_DATA = 8'h05
    } reg_addr_e;

    // Counters stick at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/pkt_fifo.sv
// pkt_fifo: length-bounded packet FIFO core (reused for tx/rx packet FIFOs).
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   rd_en / data_out      pop head onto registered data_out (0x00 when empty)
//   wr_en / data_in       push a byte unless full
//   len_wr_en / len_in    set packet length and flush all content
//   len_rd_en / len_out   registered length readback
//   full                  write count reached length (or DEPTH)
//   read_complete         read count reached a non-zero length
module pkt_fifo
    import periph_pkg::*;
#(
    parameter int unsigned DW    = periph_pkg::DW,
    parameter int unsigned DEPTH = periph_pkg::DEPTH
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          rd_en,
    input  logic          wr_en,
    input  logic [DW-1:0] data_in,
    output logic [DW-1:0] data_out,
    input  logic          len_rd_en,
    input  logic          len_wr_en,
    input  logic [DW-1:0] len_in,
    output logic [DW-1:0] len_out,
    output logic          full,
    output logic          read_complete
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

    logic [DW-1:0]    mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [CNT_W-1:0] wr_cnt, rd_cnt;
    logic [DW-1:0]    len;
    logic             push, pop;

    assign full          = ((len != '0) && (wr_cnt >= CNT_W'(len))) || (wr_cnt == DEPTH_CNT);
    assign read_complete = (len != '0) && (rd_cnt >= CNT_W'(len));

    // A length write wins over a same-cycle push/pop. Pop compares registered
    // counts, so it never sees a push issued in the same cycle.
    assign push = wr_en && !full && !len_wr_en;
    assign pop  = rd_en && (rd_cnt < wr_cnt) && !len_wr_en;

    // Storage is not reset; the flushed pointers/counts make old data unreachable.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= data_in;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            len      <= '0;
            len_out  <= '0;
            data_out <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            wr_cnt   <= '0;
            rd_cnt   <= '0;
        end else begin
            if (len_rd_en) len_out <= len;
            if (len_wr_en) begin
                len    <= len_in;
                wr_ptr <= '0;
                rd_ptr <= '0;
                wr_cnt <= '0;
                rd_cnt <= '0;
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + 1'b1;
                    wr_cnt <= sat_inc(wr_cnt);
                end
                if (pop) begin
                    data_out <= mem[rd_ptr];
                    rd_ptr   <= rd_ptr + 1'b1;
                    rd_cnt   <= sat_inc(rd_cnt);
                end else if (rd_en) begin
                    data_out <= '0;
                end
            end
        end
    end

endmodule

// File: rtl/fifo_gpo_led_periph.sv
// fifo_gpo_led_periph: register targets behind the SPI register decoder.
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   fifo_*                          packet FIFO data/length strobes, buses, full/read_complete
//   gpo_rd_en, gpo_wr_en, gpo_data_in, gpo_data_out, gpo_pins[6:0]
//   led_rd_en, led_wr_en, led_data_in, led_data_out, led0, led1
// All readbacks are registered (valid the cycle after rd_en) and hold until the next rd_en.
module fifo_gpo_led_periph
    import periph_pkg::*;
#(
    parameter int unsigned DW    = periph_pkg::DW,
    parameter int unsigned DEPTH = periph_pkg::DEPTH
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          fifo_rd_en,
    input  logic          fifo_wr_en,
    input  logic [DW-1:0] fifo_data_in,
    output logic [DW-1:0] fifo_data_out,
    input  logic          fifo_len_rd_en,
    input  logic          fifo_len_wr_en,
    input  logic [DW-1:0] fifo_len_in,
    output logic [DW-1:0] fifo_len_out,
    output logic          fifo_full,
    output logic          fifo_read_complete,
    input  logic          gpo_rd_en,
    input  logic          gpo_wr_en,
    input  logic [DW-1:0] gpo_data_in,
    output logic [DW-1:0] gpo_data_out,
    output logic [6:0]    gpo_pins,
    input  logic          led_rd_en,
    input  logic          led_wr_en,
    input  logic [DW-1:0] led_data_in,
    output logic [DW-1:0] led_data_out,
    output logic          led0,
    output logic          led1
);

    logic [DW-1:0] gpo_reg, led_reg;

    pkt_fifo #(.DW(DW), .DEPTH(DEPTH)) u_fifo (
        .clk           (clk),
        .reset         (reset),
        .rd_en         (fifo_rd_en),
        .wr_en         (fifo_wr_en),
        .data_in       (fifo_data_in),
        .data_out      (fifo_data_out),
        .len_rd_en     (fifo_len_rd_en),
        .len_wr_en     (fifo_len_wr_en),
        .len_in        (fifo_len_in),
        .len_out       (fifo_len_out),
        .full          (fifo_full),
        .read_complete (fifo_read_complete)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            gpo_reg      <= '0;
            gpo_data_out <= '0;
            led_reg      <= '0;
            led_data_out <= '0;
        end else begin
            if (gpo_wr_en) gpo_reg      <= gpo_data_in;
            if (gpo_rd_en) gpo_data_out <= gpo_reg;
            if (led_wr_en) led_reg      <= led_data_in;
            if (led_rd_en) led_data_out <= led_reg;
        end
    end

    assign gpo_pins = gpo_reg[6:0];
    assign led0     = led_reg[0];
    assign led1     = led_reg[1];

endmodule

// File: tb/tb_fifo_gpo_led_periph.sv
// Directed testbench for fifo_gpo_led_periph.
module tb_fifo_gpo_led_periph;

    logic       clk = 1'b0;
    logic       reset;
    logic       fifo_rd_en, fifo_wr_en, fifo_len_rd_en, fifo_len_wr_en;
    logic [7:0] fifo_data_in, fifo_data_out, fifo_len_in, fifo_len_out;
    logic       fifo_full, fifo_read_complete;
    logic       gpo_rd_en, gpo_wr_en;
    logic [7:0] gpo_data_in, gpo_data_out;
    logic [6:0] gpo_pins;
    logic       led_rd_en, led_wr_en;
    logic [7:0] led_data_in, led_data_out;
    logic       led0, led1;

    int tests  = 0;
    int failed = 0;

    always #5 clk = ~clk;

    fifo_gpo_led_periph #(.DW(8), .DEPTH(64)) dut (
        .clk                (clk),
        .reset              (reset),
        .fifo_rd_en         (fifo_rd_en),
        .fifo_wr_en         (fifo_wr_en),
        .fifo_data_in       (fifo_data_in),
        .fifo_data_out      (fifo_data_out),
        .fifo_len_rd_en     (fifo_len_rd_en),
        .fifo_len_wr_en     (fifo_len_wr_en),
        .fifo_len_in        (fifo_len_in),
        .fifo_len_out       (fifo_len_out),
        .fifo_full          (fifo_full),
        .fifo_read_complete (fifo_read_complete),
        .gpo_rd_en          (gpo_rd_en),
        .gpo_wr_en          (gpo_wr_en),
        .gpo_data_in        (gpo_data_in),
        .gpo_data_out       (gpo_data_out),
        .gpo_pins           (gpo_pins),
        .led_rd_en          (led_rd_en),
        .led_wr_en          (led_wr_en),
        .led_data_in        (led_data_in),
        .led_data_out       (led_data_out),
        .led0               (led0),
        .led1               (led1)
    );

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Inputs change #1 after a rising edge; outputs are sampled #1 after the next one.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        fifo_rd_en = 0; fifo_wr_en = 0; fifo_len_rd_en = 0; fifo_len_wr_en = 0;
        gpo_rd_en = 0; gpo_wr_en = 0; led_rd_en = 0; led_wr_en = 0;
    endtask

    task automatic push(input logic [7:0] d);
        fifo_wr_en = 1; fifo_data_in = d; tick(); fifo_wr_en = 0;
    endtask

    task automatic pop();
        fifo_rd_en = 1; tick(); fifo_rd_en = 0;
    endtask

    task automatic len_wr(input logic [7:0] l);
        fifo_len_wr_en = 1; fifo_len_in = l; tick(); fifo_len_wr_en = 0;
    endtask

    task automatic check_all_zero(input string pfx);
        check({pfx, "_fifo_data_out"}, fifo_data_out, 8'h00);
        check({pfx, "_fifo_len_out"},  fifo_len_out, 8'h00);
        check({pfx, "_full"},          8'(fifo_full), 8'h00);
        check({pfx, "_read_complete"}, 8'(fifo_read_complete), 8'h00);
        check({pfx, "_gpo_data_out"},  gpo_data_out, 8'h00);
        check({pfx, "_gpo_pins"},      8'(gpo_pins), 8'h00);
        check({pfx, "_led_data_out"},  led_data_out, 8'h00);
        check({pfx, "_led0"},          8'(led0), 8'h00);
        check({pfx, "_led1"},          8'(led1), 8'h00);
    endtask

    initial begin
        idle_inputs();
        fifo_data_in = 0; fifo_len_in = 0; gpo_data_in = 0; led_data_in = 0;
        reset = 1;
        tick(); tick();
        reset = 0;
        check_all_zero("rst");

        // Length 3 packet
        len_wr(8'd3);
        fifo_len_rd_en = 1; tick(); fifo_len_rd_en = 0;
        check("len_rd", fifo_len_out, 8'h03);
        check("full_empty", 8'(fifo_full), 8'h00);
        push(8'h01);
        push(8'h02);
        check("full_2of3", 8'(fifo_full), 8'h00);
        push(8'h03);
        check("full_3of3", 8'(fifo_full), 8'h01);
        push(8'hAA);
        check("full_after_drop", 8'(fifo_full), 8'h01);
        pop(); check("pop1", fifo_data_out, 8'h01);
        tick(); check("pop1_hold", fifo_data_out, 8'h01);
        pop(); check("pop2", fifo_data_out, 8'h02);
        check("rc_2of3", 8'(fifo_read_complete), 8'h00);
        pop(); check("pop3", fifo_data_out, 8'h03);
        check("rc_3of3", 8'(fifo_read_complete), 8'h01);
        pop(); check("pop4_empty", fifo_data_out, 8'h00);
        check("rc_sticky", 8'(fifo_read_complete), 8'h01);

        // Length rewrite flushes
        len_wr(8'd2);
        check("rw_full", 8'(fifo_full), 8'h00);
        check("rw_rc", 8'(fifo_read_complete), 8'h00);
        push(8'h55);
        push(8'h66);
        check("rw_full2", 8'(fifo_full), 8'h01);
        pop(); check("rw_pop55", fifo_data_out, 8'h55);
        pop(); check("rw_pop66", fifo_data_out, 8'h66);
        check("rw_rc2", 8'(fifo_read_complete), 8'h01);

        // Length write beats a same-cycle push
        fifo_len_wr_en = 1; fifo_len_in = 8'd2; fifo_wr_en = 1; fifo_data_in = 8'hAB;
        tick(); idle_inputs();
        pop(); check("lenwr_drops_push", fifo_data_out, 8'h00);

        // len 0: simultaneous push/pop behaviour
        len_wr(8'd0);
        fifo_wr_en = 1; fifo_data_in = 8'h99; fifo_rd_en = 1;
        tick(); idle_inputs();
        check("pop_empty_same_push", fifo_data_out, 8'h00);
        fifo_wr_en = 1; fifo_data_in = 8'h88; fifo_rd_en = 1;
        tick(); idle_inputs();
        check("sim_pop99", fifo_data_out, 8'h99);
        pop(); check("pop88", fifo_data_out, 8'h88);
        pop(); check("len0_empty", fifo_data_out, 8'h00);
        check("len0_rc", 8'(fifo_read_complete), 8'h00);

        // len 0: full only at DEPTH
        len_wr(8'd0);
        for (int i = 0; i < 64; i++) begin
            push(8'(i + 16));
            if (i == 62) check("full_at_63", 8'(fifo_full), 8'h00);
        end
        check("full_at_64", 8'(fifo_full), 8'h01);
        push(8'hEE);
        for (int i = 0; i < 64; i++) begin
            pop();
            check($sformatf("depth_pop%0d", i), fifo_data_out, 8'(i + 16));
        end
        pop(); check("depth_pop_empty", fifo_data_out, 8'h00);
        check("depth_rc", 8'(fifo_read_complete), 8'h00);

        // GPO / LED
        gpo_wr_en = 1; gpo_data_in = 8'hFF; tick(); gpo_wr_en = 0;
        check("gpo_pins", 8'(gpo_pins), 8'h7F);
        check("gpo_no_rd_yet", gpo_data_out, 8'h00);
        gpo_rd_en = 1; tick(); gpo_rd_en = 0;
        check("gpo_rd", gpo_data_out, 8'hFF);
        led_wr_en = 1; led_data_in = 8'h02; tick(); led_wr_en = 0;
        check("led1", 8'(led1), 8'h01);
        check("led0", 8'(led0), 8'h00);
        led_rd_en = 1; tick(); led_rd_en = 0;
        check("led_rd", led_data_out, 8'h02);

        // Reset mid-packet
        len_wr(8'd4);
        push(8'h21); push(8'h22); push(8'h23);
        pop(); check("pre_rst_pop", fifo_data_out, 8'h21);
        fifo_len_rd_en = 1; tick(); fifo_len_rd_en = 0;
        check("pre_rst_len", fifo_len_out, 8'h04);
        reset = 1; tick(); reset = 0;
        check_all_zero("midrst");
        pop(); check("post_rst_empty", fifo_data_out, 8'h00);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
